ram_port_responder: RTL and testbench

Synchronous single-port RAM with valid/ready request and response channels. It replaces the bare write/select RAM access with a handshaked memory endpoint. Requesting blocks such as sequencers and BIST engines issue writes and reads, and read data returns on a separate buffered response channel. After reset, an internal sequencer fills every location with INIT_VAL before the block accepts any request.

---
 rtl/ram_port_responder.sv | 96 +++++++++
 tb/tb_ram_port_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_responder.sv
// ram_port_responder: single-port RAM behind a valid/ready request channel
// with a one-entry buffered read-response channel. After reset a fill
// sequencer writes INIT_VAL to every location before any request is taken.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_FILL | writing INIT_VAL to mem[fill_ptr], requests blocked
// ST_RUN  | operational, requests accepted per handshake rules
module ram_port_responder #(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] fill_ptr;
  logic              init_done_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic accept;
  logic wr_accept;
  logic rd_accept;

  // A new request may enter only when the response slot is empty or is
  // being drained this cycle, which also keeps writes strictly in order
  // behind a stalled read.
  assign req_ready = init_done_q && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign wr_accept = accept && req_write;
  assign rd_accept = accept && !req_write;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

  // Fill sequencer: walk every address once, then stay in RUN until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FILL;
      fill_ptr    <= '0;
      init_done_q <= 1'b0;
    end else if (state == ST_FILL) begin
      fill_ptr <= fill_ptr + 1'b1;
      if (fill_ptr == LAST_ADDR) begin
        state       <= ST_RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  // Memory write port, shared between the fill sequencer and write requests.
  // Contents are deliberately not touched by reset; the fill clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_FILL) begin
        mem[fill_ptr] <= INIT_VAL;
      end else if (wr_accept) begin
        mem[req_addr] <= req_wdata;
      end
    end
  end

  // Response buffer: load on read accept, drain on rsp_ready, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (rd_accept) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= mem[req_addr];
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_port_responder.sv
// Directed testbench for ram_port_responder (default parameters).
module tb_ram_port_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [3:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_rdata;
  logic       init_done;

  int checks = 0;
  int errors = 0;
  logic [3:0] model [16];

  ram_port_responder #(.ADDR_W(4), .DATA_W(4), .INIT_VAL(4'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Present one request for exactly one edge; caller guarantees req_ready.
  task automatic drive(input logic w, input logic [3:0] a, input logic [3:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (w) model[a] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b1;   // held during fill; must be ignored
    req_write = 1'b1;
    req_addr  = 4'h3;
    req_wdata = 4'hF;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 4'h0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b rdata=%h done=%b, want 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, init_done);
    end
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (init_done !== (i == 16) || req_ready !== (i == 16)) begin
        errors++;
        $display("FAIL fill_timing cycle %0d: done=%b ready=%b, want %b", i, init_done,
                 req_ready, (i == 16));
      end
    end
    req_valid = 1'b0;
    for (int a = 0; a < 16; a++) model[a] = 4'h0;
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 4'(a), 4'h0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h0) begin
        errors++;
        $display("FAIL fill_readback addr %0d: valid=%b rdata=%h, want 1 0", a, rsp_valid, rsp_rdata);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read;
    logic [3:0] exp [9];
    exp = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'h0};
    rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) drive(1'b1, 4'(k), 4'((2 * k) % 16));
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rsp: valid=%b, want 0", rsp_valid);
    end
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 4'(k), 4'h0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp[k]) begin
        errors++;
        $display("FAIL write_read addr %0d: valid=%b rdata=%h, want 1 %h", k, rsp_valid,
                 rsp_rdata, exp[k]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 4'h0) begin
      errors++;
      $display("FAIL rsp_drain: valid=%b rdata=%h, want 0 0 (rdata held)", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_raw;
    rsp_ready = 1'b1;
    drive(1'b1, 4'h5, 4'hA);
    drive(1'b0, 4'h5, 4'h0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 4'hA) begin
      errors++;
      $display("FAIL read_after_write: valid=%b rdata=%h, want 1 a", rsp_valid, rsp_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    drive(1'b0, 4'h3, 4'h0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'h4;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h6 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall cycle %0d: valid=%b rdata=%h ready=%b, want 1 6 0", i, rsp_valid,
                 rsp_rdata, req_ready);
      end
      @(posedge clk);
      #1;
    end
    // A write must not slip past the stalled read either.
    req_write = 1'b1;
    req_wdata = 4'hF;
    @(posedge clk);
    #1;
    req_write = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h6 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_write: valid=%b rdata=%h ready=%b, want 1 6 0", rsp_valid, rsp_rdata,
               req_ready);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_comb: ready=%b, want 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h8) begin
      errors++;
      $display("FAIL handoff: valid=%b rdata=%h, want 1 8", rsp_valid, rsp_rdata);
    end
    drive(1'b0, 4'h4, 4'h0);
    checks++;
    if (model[4] !== 4'h8 || rsp_rdata !== 4'h8) begin
      errors++;
      $display("FAIL no_write_bypass: rdata=%h, want 8", rsp_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming;
    logic [3:0] a;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 4'($urandom_range(0, 7));
      drive(1'b0, a, 4'h0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== model[a]) begin
        errors++;
        $display("FAIL stream %0d addr %0d: valid=%b rdata=%h, want 1 %h", i, a, rsp_valid,
                 rsp_rdata, model[a]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0;
    drive(1'b0, 4'h5, 4'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || rsp_rdata !== 4'h0) begin
      errors++;
      $display("FAIL reset_run: valid=%b done=%b rdata=%h, want 0 0 0", rsp_valid, init_done,
               rsp_rdata);
    end
    rsp_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill: valid=%b done=%b, want 0 0", rsp_valid, init_done);
    end
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (init_done !== (i == 16)) begin
        errors++;
        $display("FAIL refill_timing cycle %0d: done=%b, want %b", i, init_done, (i == 16));
      end
    end
    for (int a = 0; a < 16; a++) model[a] = 4'h0;
    for (int a = 0; a < 9; a++) begin
      drive(1'b0, 4'(a), 4'h0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h0) begin
        errors++;
        $display("FAIL refill_readback addr %0d: valid=%b rdata=%h, want 1 0", a, rsp_valid,
                 rsp_rdata);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_raw;
    test_backpressure;
    test_streaming;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
